// File: rtl/gpio_link_slave.sv
// gpio_link_slave: fabric-side responder for the MCU high-bank GPIO serial link.
// The MCU bit-bangs an SPI-like framed byte stream. It is oversampled on ppm_clk,
// received bytes go to fabric, and fabric bytes are shifted back on MISO.
//
// Ports:
//   ppm_clk, rst            sole clock, asynchronous active-high reset
//   gpio_h0_out             link SCK from the MCU
//   gpio_h0_oe_n            link CS_N from the MCU (low = frame active)
//   gpio_h1_out             link MOSI from the MCU
//   gpio_h1_oe_n            unused tie-off
//   gpio_h0_in              registered copy of tx_valid (TX-available flag)
//   gpio_h1_in              link MISO to the MCU (1 while idle)
//   rx_data, rx_valid       received byte, MSB first, with a one-cycle valid pulse
//   tx_data, tx_valid       next byte to return to the MCU
//   tx_ready / tx_under     one-cycle pulse per TX load: consumed / nothing available
//   frame_abort             one-cycle pulse when CS_N rises with a partial byte
//   rx_perr                 parity error pulse (GPIO_LINK_PARITY_EN builds only)
//
// Build option: define GPIO_LINK_PARITY_EN for 9-bit frames with an odd-parity bit.

module gpio_link_slave (
  input  logic       ppm_clk,
  input  logic       rst,
  input  logic       gpio_h0_out,
  input  logic       gpio_h0_oe_n,
  input  logic       gpio_h1_out,
  input  logic       gpio_h1_oe_n,
  output logic       gpio_h0_in,
  output logic       gpio_h1_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_under,
  output logic       frame_abort
`ifdef GPIO_LINK_PARITY_EN
  ,
  output logic       rx_perr
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef GPIO_LINK_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic       r_sck_s1, r_sck_s2, r_sck_d;
  logic       r_cs_s1, r_cs_s2, r_cs_d;
  logic       r_mosi_s1, r_mosi_s2;
  logic [1:0] r_fill;
  logic       r_armed;
  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic       r_miso;
  logic       r_tx_avail;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_tx_ready, r_tx_under, r_abort;
`ifdef GPIO_LINK_PARITY_EN
  logic       r_tx_par;
  logic       r_perr;
  logic       w_par_drive;
  logic       w_perr;
`endif

  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [7:0] w_rx_byte, w_rx_out, w_load_byte;
  logic [1:0] w_state_d;
  logic       w_load, w_rx_shift, w_tx_shift, w_rx_done, w_abort;
  logic       w_unused;

  assign w_unused    = gpio_h1_oe_n;
  assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_rx_byte   = {r_rx_sh[6:0], r_mosi_s2};
  assign w_load_byte = tx_valid ? tx_data : 8'h00;
`ifdef GPIO_LINK_PARITY_EN
  // The full byte already sits in the shifter when the parity bit arrives.
  assign w_rx_out = r_rx_sh;
`else
  assign w_rx_out = w_rx_byte;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_rx_shift = 1'b0;
    w_tx_shift = 1'b0;
    w_rx_done  = 1'b0;
    w_abort    = 1'b0;
`ifdef GPIO_LINK_PARITY_EN
    w_par_drive = 1'b0;
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Only a falling edge seen after a genuine high level starts a frame.
        if (w_cs_fall && r_armed) begin
          w_state_d = ST_SHIFT;
          w_load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_d = ST_IDLE;
          w_abort   = (r_cnt != 3'd0);
        end else if (w_sck_rise) begin
          w_rx_shift = 1'b1;
          if (r_cnt == 3'd7) begin
`ifdef GPIO_LINK_PARITY_EN
            w_state_d = ST_PARITY;
`else
            w_rx_done = 1'b1;
            w_load    = 1'b1;
`endif
          end
        end else if (w_sck_fall && r_cnt != 3'd0) begin
          // The falling edge after a byte boundary must not shift the freshly loaded MSB.
          w_tx_shift = 1'b1;
        end
      end
`ifdef GPIO_LINK_PARITY_EN
      ST_PARITY: begin
        if (w_cs_rise) begin
          w_state_d = ST_IDLE;
          w_abort   = 1'b1;
        end else if (w_sck_rise) begin
          w_state_d = ST_SHIFT;
          w_load    = 1'b1;
          if (^{r_rx_sh, r_mosi_s2}) w_rx_done = 1'b1;
          else                       w_perr    = 1'b1;
        end else if (w_sck_fall) begin
          w_par_drive = 1'b1;
        end
      end
`endif
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ppm_clk or posedge rst) begin
    if (rst) begin
      r_sck_s1   <= 1'b1;
      r_sck_s2   <= 1'b1;
      r_sck_d    <= 1'b1;
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_cs_d     <= 1'b1;
      r_mosi_s1  <= 1'b1;
      r_mosi_s2  <= 1'b1;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_rx_sh    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_miso     <= 1'b1;
      r_tx_avail <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_under <= 1'b0;
      r_abort    <= 1'b0;
`ifdef GPIO_LINK_PARITY_EN
      r_tx_par   <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_sck_s1   <= gpio_h0_out;
      r_sck_s2   <= r_sck_s1;
      r_sck_d    <= r_sck_s2;
      r_cs_s1    <= gpio_h0_oe_n;
      r_cs_s2    <= r_cs_s1;
      r_cs_d     <= r_cs_s2;
      r_mosi_s1  <= gpio_h1_out;
      r_mosi_s2  <= r_mosi_s1;
      // r_cs_s2 holds a real sample only once r_fill is full; until then it is the reset value.
      r_fill     <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_cs_s2) r_armed <= 1'b1;
      r_tx_avail <= tx_valid;
      r_state    <= w_state_d;
      if (w_state_d == ST_IDLE) r_cnt <= 3'd0;
      else if (w_rx_shift)      r_cnt <= r_cnt + 3'd1;
      if (w_rx_shift) r_rx_sh <= w_rx_byte;
      if (w_rx_done)  r_rx_data <= w_rx_out;
      r_rx_valid <= w_rx_done;
      r_tx_ready <= w_load & tx_valid;
      r_tx_under <= w_load & ~tx_valid;
      r_abort    <= w_abort;
      if (w_load)          r_tx_sh <= w_load_byte;
      else if (w_tx_shift) r_tx_sh <= {r_tx_sh[6:0], 1'b0};
`ifdef GPIO_LINK_PARITY_EN
      r_perr <= w_perr;
      if (w_load) r_tx_par <= ~^w_load_byte;
      if (w_state_d == ST_IDLE) r_miso <= 1'b1;
      else if (w_load)          r_miso <= w_load_byte[7];
      else if (w_tx_shift)      r_miso <= r_tx_sh[6];
      else if (w_par_drive)     r_miso <= r_tx_par;
`else
      if (w_state_d == ST_IDLE) r_miso <= 1'b1;
      else if (w_load)          r_miso <= w_load_byte[7];
      else if (w_tx_shift)      r_miso <= r_tx_sh[6];
`endif
    end
  end

  assign gpio_h0_in  = r_tx_avail;
  assign gpio_h1_in  = r_miso;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = r_tx_ready;
  assign tx_under    = r_tx_under;
  assign frame_abort = r_abort;
`ifdef GPIO_LINK_PARITY_EN
  assign rx_perr     = r_perr;
`endif

endmodule
